// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================
// mem_stage_pkg : shared encodings for the memory-access stage
// Rev 1.0
// ============================================================
package mem_stage_pkg;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Unlisted funct3 codes are handled as full-word accesses.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================
// mem_align : store lane steering, load extraction, misalignment
// Rev 1.0
// ============================================================
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  size_t       w_size;
  logic [31:0] w_sh;

  always_comb begin
    w_size     = f3_size(funct3_i);
    w_sh       = load_word_i >> {off_i, 3'b000};
    be_o       = 4'b1111;
    wdata_o    = store_data_i;
    misalign_o = 1'b0;
    case (w_size)
      SZ_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      SZ_H: begin
        be_o       = 4'b0011 << off_i;
        wdata_o    = {2{store_data_i[15:0]}};
        misalign_o = off_i[0];
      end
      default: begin
        be_o       = 4'b1111;
        misalign_o = |off_i;
      end
    endcase

    // Word loads are always aligned here, so w_sh equals the raw word.
    case (funct3_i)
      F3_B:    load_data_o = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_BU:   load_data_o = {24'h000000, w_sh[7:0]};
      F3_H:    load_data_o = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_HU:   load_data_o = {16'h0000, w_sh[15:0]};
      default: load_data_o = w_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================
// mem_stage : memory-access stage with req/gnt/rvalid data bus
// Rev 1.0
// ============================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [1:0]  mem_op_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_we_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int             CNT_W       = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(MAX_WAIT);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr, r_wdata;
  logic [3:0]       r_be;
  logic             r_we, r_rd_we;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd_addr;

  logic        w_is_mem, w_accept, w_start;
  logic        w_store_done, w_load_done, w_timeout;
  logic [1:0]  w_off;
  logic [2:0]  w_funct3;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_data;
  logic        w_misalign;

  // Idle: steer the incoming instruction; busy: extract with the latched access.
  assign w_off    = (r_state == ST_IDLE) ? alu_result_i[1:0] : r_addr[1:0];
  assign w_funct3 = (r_state == ST_IDLE) ? funct3_i : r_funct3;

  mem_align u_align (
    .off_i        (w_off),
    .funct3_i     (w_funct3),
    .store_data_i (rs2_data_i),
    .load_word_i  (dmem_rdata_i),
    .be_o         (w_be),
    .wdata_o      (w_wdata),
    .load_data_o  (w_load_data),
    .misalign_o   (w_misalign)
  );

  always_comb begin
    case (mem_op_i)
      MEM_LOAD, MEM_STORE: w_is_mem = 1'b1;
      MEM_NONE:            w_is_mem = 1'b0;
      default:             w_is_mem = 1'b0;
    endcase
  end

  assign w_accept     = valid_i && (r_state == ST_IDLE);
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = {r_addr[31:2], 2'b00};
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_store_done = 1'b0;
    w_load_done  = 1'b0;
    w_timeout    = 1'b0;
    ready_o      = (r_state == ST_IDLE);
    dmem_req_o   = (r_state == ST_REQ);
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mem && !w_misalign) begin
          w_start     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          w_store_done = r_we;
          w_state_nxt  = r_we ? ST_IDLE : ST_WAIT;
        end else if (r_cnt >= C_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A grant in the last REQ cycle still leaves one WAIT cycle for rvalid.
        if (dmem_rvalid_i) begin
          w_load_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt >= C_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt <= '0;
      end else if (r_state != ST_IDLE && r_cnt != C_CNT_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_we       <= 1'b0;
      r_funct3   <= '0;
      r_rd_addr  <= '0;
      r_rd_we    <= 1'b0;
      valid_o    <= 1'b0;
      rd_addr_o  <= '0;
      rd_we_o    <= 1'b0;
      wb_data_o  <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      rd_we_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;

      if (w_start) begin
        r_addr    <= alu_result_i;
        r_wdata   <= w_wdata;
        r_be      <= w_be;
        r_we      <= (mem_op_i == MEM_STORE);
        r_funct3  <= funct3_i;
        r_rd_addr <= rd_addr_i;
        r_rd_we   <= rd_we_i;
      end

      if (w_accept && !w_is_mem) begin
        valid_o   <= 1'b1;
        rd_we_o   <= rd_we_i;
        rd_addr_o <= rd_addr_i;
        case (wb_sel_i)
          WB_PC4:         wb_data_o <= pc_plus4_i;
          WB_ALU, WB_MEM: wb_data_o <= alu_result_i;
          default:        wb_data_o <= alu_result_i;
        endcase
      end else if (w_accept && w_misalign) begin
        valid_o    <= 1'b1;
        misalign_o <= 1'b1;
        rd_addr_o  <= rd_addr_i;
      end

      if (w_store_done) begin
        valid_o   <= 1'b1;
        rd_addr_o <= r_rd_addr;
      end
      if (w_load_done) begin
        valid_o   <= 1'b1;
        rd_we_o   <= r_rd_we;
        rd_addr_o <= r_rd_addr;
        wb_data_o <= w_load_data;
      end
      if (w_timeout) begin
        valid_o   <= 1'b1;
        bus_err_o <= 1'b1;
        rd_addr_o <= r_rd_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================
// tb_mem_stage : vector table, directed reset cases, random model
// Rev 1.0
// ============================================================
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_i = 1'b0, ready_o;
  logic [31:0] alu_result_i = '0, rs2_data_i = '0, pc_plus4_i = '0;
  logic [1:0]  mem_op_i = '0, wb_sel_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_we_i = 1'b0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        valid_o, rd_we_o, misalign_o, bus_err_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wb_data_o;

  mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .pc_plus4_i(pc_plus4_i),
    .mem_op_i(mem_op_i), .funct3_i(funct3_i), .wb_sel_i(wb_sel_i),
    .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  int total = 0;
  int bad   = 0;

  // g: REQ cycle index carrying gnt; w: WAIT cycle index carrying rvalid.
  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, pc4;
    logic [1:0]  wsel;
    logic [4:0]  rd;
    logic        rdwe;
    int          g, w;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    int          e_reqcyc;
    logic        e_rdwe, e_mis, e_err, chk;
    logic [31:0] e_data;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t in_v(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] rs2, input logic [31:0] pc4, input logic [1:0] wsel,
                                input logic [4:0] rd, input logic rdwe, input int g, input int w,
                                input logic [31:0] rdata);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.pc4 = pc4; v.wsel = wsel;
    v.rd = rd; v.rdwe = rdwe; v.g = g; v.w = w; v.rdata = rdata;
    v.e_req = 1'b0; v.e_addr = '0; v.e_be = '0; v.e_wdata = '0; v.e_reqcyc = 0;
    v.e_rdwe = 1'b0; v.e_mis = 1'b0; v.e_err = 1'b0; v.chk = 1'b0; v.e_data = '0;
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t vi, input logic e_req, input logic [31:0] e_addr,
                                    input logic [3:0] e_be, input logic [31:0] e_wdata, input int e_reqcyc,
                                    input logic e_rdwe, input logic e_mis, input logic e_err,
                                    input logic chk_d, input logic [31:0] e_data);
    vec_t v = vi;
    v.e_req = e_req; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_reqcyc = e_reqcyc;
    v.e_rdwe = e_rdwe; v.e_mis = e_mis; v.e_err = e_err; v.chk = chk_d; v.e_data = e_data;
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] word);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    case (f3)
      3'b000:  return {{24{b[off][7]}}, b[off]};
      3'b100:  return {24'h0, b[off]};
      3'b001:  return {{16{b[off+1][7]}}, b[off+1], b[off]};
      3'b101:  return {16'h0, b[off+1], b[off]};
      default: return word;
    endcase
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   size, off, last;
    bit   is_mem, mis;
    r      = in_v(v.op, v.f3, v.addr, v.rs2, v.pc4, v.wsel, v.rd, v.rdwe, v.g, v.w, v.rdata);
    is_mem = (v.op == MEM_LOAD) || (v.op == MEM_STORE);
    size   = (v.f3 == F3_B || v.f3 == F3_BU) ? 1 : (v.f3 == F3_H || v.f3 == F3_HU) ? 2 : 4;
    off    = int'(v.addr[1:0]);
    mis    = is_mem && ((off % size) != 0);
    r.e_addr = v.addr & ~32'h3;
    for (int i = 0; i < 4; i++) begin
      r.e_be[i] = (i >= off) && (i < off + size);
      r.e_wdata[8*i +: 8] = v.rs2[8*(i % size) +: 8];
    end
    if (!is_mem) begin
      r.e_rdwe = v.rdwe;
      r.chk    = 1'b1;
      r.e_data = (v.wsel == WB_PC4) ? v.pc4 : v.addr;
    end else if (mis) begin
      r.e_mis = 1'b1;
    end else begin
      r.e_req    = 1'b1;
      r.e_reqcyc = (v.g < MAX_WAIT) ? v.g + 1 : MAX_WAIT;
      last       = (v.op == MEM_STORE) ? v.g : v.g + 1 + v.w;
      if (last <= MAX_WAIT - 1) begin
        if (v.op == MEM_LOAD) begin
          r.e_rdwe = v.rdwe;
          r.chk    = 1'b1;
          r.e_data = ref_load(v.f3, off, v.rdata);
        end
      end else begin
        r.e_err = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    int reqcyc;
    bit done;
    chk({nm, "/ready"}, 64'(ready_o), 64'd1);
    valid_i = 1'b1; mem_op_i = v.op; funct3_i = v.f3; alu_result_i = v.addr;
    rs2_data_i = v.rs2; pc_plus4_i = v.pc4; wb_sel_i = v.wsel; rd_addr_i = v.rd; rd_we_i = v.rdwe;
    step();
    valid_i = 1'b0; alu_result_i = $urandom; rs2_data_i = $urandom;
    chk({nm, "/req"}, 64'(dmem_req_o), 64'(v.e_req));
    if (v.e_req) begin
      chk({nm, "/bus"}, {27'd0, dmem_we_o, dmem_be_o, dmem_addr_o},
          {27'd0, (v.op == MEM_STORE), v.e_be, v.e_addr});
      if (v.op == MEM_STORE) chk({nm, "/wdata"}, 64'(dmem_wdata_o), 64'(v.e_wdata));
    end
    reqcyc = 0;
    done   = valid_o;
    for (int c = 0; c < 3 * MAX_WAIT && !done; c++) begin
      if (dmem_req_o) reqcyc++;
      dmem_gnt_i    = (c == v.g);
      dmem_rvalid_i = (v.op == MEM_LOAD) && (c == v.g + 1 + v.w);
      dmem_rdata_i  = dmem_rvalid_i ? v.rdata : $urandom;
      step();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      done          = valid_o;
    end
    chk({nm, "/valid"}, 64'(valid_o), 64'd1);
    if (v.e_req) chk({nm, "/reqcyc"}, 64'(reqcyc), 64'(v.e_reqcyc));
    chk({nm, "/flags"}, {61'd0, rd_we_o, misalign_o, bus_err_o}, {61'd0, v.e_rdwe, v.e_mis, v.e_err});
    if (v.chk) chk({nm, "/data"}, {27'd0, rd_addr_o, wb_data_o}, {27'd0, v.rd, v.e_data});
    step();
    chk({nm, "/idle"}, {59'd0, valid_o, rd_we_o, misalign_o, bus_err_o, ready_o}, 64'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "/ctl"}, {49'd0, valid_o, rd_we_o, misalign_o, bus_err_o, dmem_req_o, dmem_we_o,
                       dmem_be_o, rd_addr_o}, 64'd0);
    chk({nm, "/wbaddr"}, {wb_data_o, dmem_addr_o}, 64'd0);
    chk({nm, "/wdata"}, 64'(dmem_wdata_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   seen;
    logic [2:0] f3s [5];
    f3s[0] = F3_B; f3s[1] = F3_H; f3s[2] = F3_W; f3s[3] = F3_BU; f3s[4] = F3_HU;

    tbl.push_back(with_exp(in_v(MEM_NONE, 3'd0, 32'h1234, 32'h0, 32'h4, WB_ALU, 5'd5, 1'b1, 0, 0, 32'h0),
                  1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234));
    tbl.push_back(with_exp(in_v(MEM_NONE, 3'd0, 32'hDEAD0000, 32'h0, 32'h104, WB_PC4, 5'd1, 1'b1, 0, 0, 32'h0),
                  1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h104));
    tbl.push_back(with_exp(in_v(MEM_STORE, F3_B, 32'h1003, 32'hAB, 32'h0, WB_ALU, 5'd0, 1'b0, 2, 0, 32'h0),
                  1'b1, 32'h1000, 4'b1000, 32'hABABABAB, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(with_exp(in_v(MEM_LOAD, F3_B, 32'h2002, 32'h0, 32'h0, WB_MEM, 5'd7, 1'b1, 1, 1, 32'h00800000),
                  1'b1, 32'h2000, 4'b0100, 32'h0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80));
    tbl.push_back(with_exp(in_v(MEM_LOAD, F3_BU, 32'h2002, 32'h0, 32'h0, WB_MEM, 5'd7, 1'b1, 1, 1, 32'h00800000),
                  1'b1, 32'h2000, 4'b0100, 32'h0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000080));
    tbl.push_back(with_exp(in_v(MEM_LOAD, F3_W, 32'h2001, 32'h0, 32'h0, WB_MEM, 5'd9, 1'b1, 0, 0, 32'h0),
                  1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(with_exp(in_v(MEM_LOAD, F3_W, 32'h4000, 32'h0, 32'h0, WB_MEM, 5'd3, 1'b1, 99, 0, 32'h0),
                  1'b1, 32'h4000, 4'hF, 32'h0, 16, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(with_exp(in_v(MEM_LOAD, F3_H, 32'h2002, 32'h0, 32'h0, WB_MEM, 5'd4, 1'b1, 0, 2, 32'h80010000),
                  1'b1, 32'h2000, 4'b1100, 32'h0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF8001));
    tbl.push_back(with_exp(in_v(MEM_LOAD, F3_HU, 32'h2002, 32'h0, 32'h0, WB_MEM, 5'd4, 1'b1, 0, 2, 32'h80010000),
                  1'b1, 32'h2000, 4'b1100, 32'h0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00008001));
    tbl.push_back(with_exp(in_v(MEM_STORE, F3_H, 32'h2006, 32'h1234ABCD, 32'h0, WB_ALU, 5'd0, 1'b0, 1, 0, 32'h0),
                  1'b1, 32'h2004, 4'b1100, 32'hABCDABCD, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(with_exp(in_v(MEM_STORE, F3_W, 32'h3000, 32'hCAFEF00D, 32'h0, WB_ALU, 5'd0, 1'b0, 0, 0, 32'h0),
                  1'b1, 32'h3000, 4'hF, 32'hCAFEF00D, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(with_exp(in_v(MEM_STORE, F3_W, 32'h3004, 32'h12345678, 32'h0, WB_ALU, 5'd0, 1'b0, 15, 0, 32'h0),
                  1'b1, 32'h3004, 4'hF, 32'h12345678, 16, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(with_exp(in_v(MEM_LOAD, F3_W, 32'h5000, 32'h0, 32'h0, WB_MEM, 5'd6, 1'b1, 3, 11, 32'h55AA1234),
                  1'b1, 32'h5000, 4'hF, 32'h0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55AA1234));
    tbl.push_back(with_exp(in_v(MEM_LOAD, F3_W, 32'h5000, 32'h0, 32'h0, WB_MEM, 5'd6, 1'b1, 3, 12, 32'h55AA1234),
                  1'b1, 32'h5000, 4'hF, 32'h0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    tbl.push_back(with_exp(in_v(MEM_STORE, F3_H, 32'h3001, 32'h5555, 32'h0, WB_ALU, 5'd0, 1'b0, 0, 0, 32'h0),
                  1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(with_exp(in_v(2'd3, 3'd0, 32'h77, 32'h0, 32'h0, WB_ALU, 5'd2, 1'b1, 0, 0, 32'h0),
                  1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77));
    tbl.push_back(with_exp(in_v(MEM_LOAD, F3_W, 32'h2000, 32'h0, 32'h0, WB_MEM, 5'd31, 1'b0, 0, 0, 32'h89ABCDEF),
                  1'b1, 32'h2000, 4'hF, 32'h0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h89ABCDEF));

    // Reset state.
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset/ready", 64'(ready_o), 64'd1);

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back non-memory instructions, one per cycle.
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; mem_op_i = MEM_NONE; wb_sel_i = WB_ALU;
      alu_result_i = 32'h100 + 32'(i); rd_addr_i = 5'(i + 1); rd_we_i = 1'b1;
      step();
      chk($sformatf("b2b%0d", i), {25'd0, valid_o, ready_o, rd_addr_o, wb_data_o},
          {25'd0, 1'b1, 1'b1, 5'(i + 1), 32'h100 + 32'(i)});
    end
    valid_i = 1'b0;
    step();

    for (int n = 0; n < 200; n++) begin
      v = in_v(2'($urandom_range(0, 3)), f3s[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
               2'd0, 5'($urandom), 1'($urandom), 0, 0, $urandom);
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      v.wsel = (v.op == MEM_LOAD || v.op == MEM_STORE) ? WB_MEM : ($urandom_range(0, 1) == 1 ? WB_PC4 : WB_ALU);
      case ($urandom_range(0, 9))
        0:       v.g = 14;
        1:       v.g = 20;
        default: v.g = $urandom_range(0, 6);
      endcase
      v.w = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 8);
      run_txn(model(v), $sformatf("rnd%0d", n));
    end

    // Reset while REQ is asserted: the request must drop at once.
    valid_i = 1'b1; mem_op_i = MEM_LOAD; funct3_i = F3_W; alu_result_i = 32'h6000; rd_addr_i = 5'd8; rd_we_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("rstreq/pre", 64'(dmem_req_o), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rstreq");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset in WAIT, then a stale rvalid must not produce a writeback.
    run_txn(tbl[0], "rstwait_pre");
    valid_i = 1'b1; mem_op_i = MEM_LOAD; funct3_i = F3_W; alu_result_i = 32'h7004;
    rs2_data_i = 32'h11; rd_addr_i = 5'd8; rd_we_i = 1'b1;
    step();
    valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("rstwait/busy", {62'd0, ready_o, dmem_req_o}, 64'd0);
    #2 rst_n = 1'b0;
    #1 chk_zero("rstwait");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD;
    step();
    dmem_rvalid_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      seen += int'(valid_o);
      step();
    end
    chk("rstwait/late_rvalid", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Takes the ALU result (effective address or computed value), store data and writeback control from execute, and performs loads and stores on the data-memory bus using a req/gnt/rvalid handshake.
- Produces a registered writeback packet for the writeback stage: ALU result, aligned and extended load data, or pc+4.
- Stalls execute via ready_o while a bus transaction is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
- MAX_WAIT, 16, cycles allowed in REQ or WAIT before the transaction is aborted with bus_err_o.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  execute presents an instruction.
- ready_o  out  1  stage accepts an instruction this cycle.
- alu_result_i  in  32  address for loads/stores; result otherwise.
- rs2_data_i  in  32  store data.
- pc_plus4_i  in  32  return address for jal/jalr.
- mem_op_i  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none).
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- wb_sel_i  in  2  0 ALU, 1 memory, 2 pc+4.
- rd_addr_i  in  5  destination register.
- rd_we_i  in  1  destination write enable.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-aligned write data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  32  read data.
- valid_o  out  1  writeback packet valid (one-cycle pulse).
- rd_addr_o  out  5  destination register.
- rd_we_o  out  1  register write enable.
- wb_data_o  out  32  writeback data.
- misalign_o  out  1  one-cycle pulse on a misaligned access.
- bus_err_o  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset (async, asserted low):
  - State returns to IDLE; the wait counter clears.
  - All outputs go to 0, including dmem_req_o, which drops immediately even mid-transaction.
  - Any outstanding transaction is abandoned; an rvalid arriving after reset is ignored.
- FSM states are IDLE, REQ and WAIT.
- ready_o = (state == IDLE). The writeback stage always accepts.
- Instruction accepted when valid_i && ready_o:
  - mem_op none: next cycle valid_o=1, rd_we_o=rd_we_i, rd_addr_o=rd_addr_i, wb_data_o = alu_result_i (wb_sel 0) or pc_plus4_i (wb_sel 2). Latency 1; state stays IDLE.
  - Misaligned load/store (H with addr[0]=1, W with addr[1:0]!=0): no bus request is issued. Next cycle valid_o=1, rd_we_o=0, misalign_o=1.
  - Aligned load/store: latch address, data, funct3, rd and rd_we; go to REQ.
- REQ state:
  - dmem_req_o=1, with address, we, be and wdata held stable from registers.
  - On dmem_gnt_i: a store completes (next cycle valid_o=1, rd_we_o=0, return to IDLE); a load goes to WAIT.
- WAIT state:
  - On dmem_rvalid_i: valid_o=1 next cycle, wb_data_o = extended load data, rd_we_o = latched rd_we; return to IDLE.
  - gnt and rvalid in the same cycle is not legal; rvalid is only sampled in WAIT.
- Store lanes, with off = addr[1:0]:
  - SB: be = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<off, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
  - Loads drive be as above and we=0.
- Load extraction:
  - sh = dmem_rdata_i >> (8*off).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: the whole word.
  - Any other funct3 behaves as LW.
- Timeout:
  - The counter clears on entering REQ and counts each cycle in REQ or WAIT.
  - If it reaches MAX_WAIT-1 without the awaited gnt/rvalid: drop req, return to IDLE, next cycle valid_o=1, rd_we_o=0, bus_err_o=1.
  - A gnt or rvalid arriving in that same final cycle wins over the timeout.
- When valid_o=0, rd_we_o=0 and other outputs hold their last values. Back-to-back non-memory instructions sustain 1 per cycle.

Decomposition:
- Shared package holds:
  - mem_op encodings (MEM_NONE/LOAD/STORE).
  - funct3 size codes (F3_B/H/W/BU/HU).
  - wb_sel codes (WB_ALU/MEM/PC4).
  - FSM state typedef.
- One natural sub-module, mem_align: purely combinational store lane/byte-enable generation, load extraction and misalignment detection. The FSM, counter and output registers stay in mem_stage.

Test Plan:
- Non-memory: alu_result_i=0x1234, wb_sel=0, rd=5, rd_we=1 -> next cycle valid_o=1, wb_data_o=0x1234, rd_addr_o=5, ready_o stays 1.
- SB: addr=0x1003, rs2=0xAB -> dmem_addr_o=0x1000, be=1000, wdata=0xABABABAB. With gnt after 2 cycles, valid_o pulses with rd_we_o=0.
- LB/LBU: addr=0x2002, rdata=0x00800000 -> LB gives wb_data_o=0xFFFFFF80; LBU gives 0x00000080.
- Misaligned LW at 0x2001 -> no dmem_req_o, misalign_o=1 and valid_o=1 with rd_we_o=0 next cycle.
- Timeout: load with gnt never asserted, MAX_WAIT=16 -> req drops after 16 cycles, bus_err_o pulses, ready_o returns to 1.
- Reset mid-WAIT, then a late rvalid -> dmem_req_o=0 and all outputs 0 immediately; the late rvalid produces no valid_o.
